// File: rtl/addertree_pipe_param.sv
// Pipelined NUM_IN-operand adder: 3:2 carry-save levels with a register every REG_EVERY
// levels, then a 3-input carry-propagate add into an optional framed accumulator.
module addertree_pipe_param #(
    parameter int NUM_IN    = 9,
    parameter int IN_W      = 16,
    parameter int SIGNED    = 1,
    parameter int ACC_EXT   = 8,
    parameter int REG_EVERY = 2,
    parameter int OUT_W     = IN_W + $clog2(NUM_IN) + ACC_EXT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    input  logic                   in_acc,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_sum
);

    function automatic int rows_at(input int n_in, input int lvl);
        int r;
        r = n_in;
        for (int i = 0; i < lvl; i++) r = 2 * (r / 3) + r % 3;
        return r;
    endfunction

    function automatic int num_levels(input int n_in);
        int r;
        int n;
        r = n_in;
        n = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            n++;
        end
        return n;
    endfunction

    localparam int NLVL = num_levels(NUM_IN);

    logic             stall;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_sum_q, out_sum_d;
    logic [OUT_W-1:0] acc_q, acc_d;

    // One global stall: only the output register can refuse, so every stage holds together.
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    for (genvar l = 0; l <= NLVL; l++) begin : g_lvl
        localparam int R = rows_at(NUM_IN, l);
        logic [OUT_W-1:0] rows [R];
        logic             vld, acc, first, last;

        if (l == 0) begin : g_src
            for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
                logic [IN_W-1:0] op;
                assign op      = in_data[k*IN_W +: IN_W];
                assign rows[k] = {{(OUT_W-IN_W){(SIGNED != 0) && op[IN_W-1]}}, op};
            end
            assign vld   = in_valid & in_ready;
            assign acc   = in_acc;
            assign first = in_first;
            assign last  = in_last;
        end else begin : g_csa
            localparam int RI  = rows_at(NUM_IN, l - 1);
            localparam int NG  = RI / 3;
            localparam bit REG = ((l % REG_EVERY) == 0) || (l == NLVL);
            logic [OUT_W-1:0] rows_d [R];

            always_comb begin
                for (int k = 0; k < R; k++) rows_d[k] = '0;
                for (int g = 0; g < NG; g++) begin
                    rows_d[2*g]   = g_lvl[l-1].rows[3*g] ^ g_lvl[l-1].rows[3*g+1]
                                  ^ g_lvl[l-1].rows[3*g+2];
                    rows_d[2*g+1] = ((g_lvl[l-1].rows[3*g]   & g_lvl[l-1].rows[3*g+1])
                                  |  (g_lvl[l-1].rows[3*g]   & g_lvl[l-1].rows[3*g+2])
                                  |  (g_lvl[l-1].rows[3*g+1] & g_lvl[l-1].rows[3*g+2])) << 1;
                end
                // Leftover rows that do not fill a full triple pass straight down.
                for (int k = 0; k < RI - 3*NG; k++) rows_d[2*NG+k] = g_lvl[l-1].rows[3*NG+k];
            end

            if (REG) begin : g_reg
                logic [OUT_W-1:0] rows_q [R];
                logic             vld_q, vld_d;
                logic [2:0]       flg_q, flg_d;

                always_comb begin
                    vld_d = g_lvl[l-1].vld;
                    flg_d = {g_lvl[l-1].acc, g_lvl[l-1].first, g_lvl[l-1].last};
                    if (stall) begin
                        vld_d = vld_q;
                        flg_d = flg_q;
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) vld_q <= 1'b0;
                    else       vld_q <= vld_d;
                end

                always_ff @(posedge clk) begin
                    flg_q <= flg_d;
                    if (!stall) rows_q <= rows_d;
                end

                assign rows  = rows_q;
                assign vld   = vld_q;
                assign acc   = flg_q[2];
                assign first = flg_q[1];
                assign last  = flg_q[0];
            end else begin : g_comb
                assign rows  = rows_d;
                assign vld   = g_lvl[l-1].vld;
                assign acc   = g_lvl[l-1].acc;
                assign first = g_lvl[l-1].first;
                assign last  = g_lvl[l-1].last;
            end
        end
    end

    logic [OUT_W-1:0] sum_sc, acc_in, acc_sum;

    always_comb begin
        sum_sc      = g_lvl[NLVL].rows[0] + g_lvl[NLVL].rows[1];
        acc_in      = g_lvl[NLVL].first ? '0 : acc_q;
        acc_sum     = g_lvl[NLVL].rows[0] + g_lvl[NLVL].rows[1] + acc_in;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        acc_d       = acc_q;
        if (!stall) begin
            out_valid_d = 1'b0;
            if (g_lvl[NLVL].vld) begin
                if (!g_lvl[NLVL].acc) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = sum_sc;
                end else if (g_lvl[NLVL].last) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = acc_sum;
                    acc_d       = '0;
                end else begin
                    acc_d = acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_addertree_pipe_param.sv
// Bench for addertree_pipe_param: signed and unsigned default instances share stimulus and are
// checked against an accept-order sum model every cycle; three small instances sweep NUM_IN/REG_EVERY.
module tb_addertree_pipe_param;

    localparam int N  = 9;
    localparam int IW = 16;
    localparam int OW = 28;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0, in_acc = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic              out_ready = 1'b1;
    logic [N*IW-1:0]   in_data = '0;
    logic              in_ready, out_valid, u_in_ready, u_out_valid;
    logic [OW-1:0]     out_sum, u_out_sum;

    logic              sw_valid = 1'b0, sw_ctl = 1'b0, sw_ready = 1'b1;
    logic [199:0]      sw_data = '0;
    logic              r25, r3, r4, v25, v3, v4;
    logic [20:0]       s25;
    logic [17:0]       s3, s4;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    always #5 clk = ~clk;

    addertree_pipe_param dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_acc(in_acc), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum));

    addertree_pipe_param #(.SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
        .in_acc(in_acc), .in_first(in_first), .in_last(in_last),
        .out_valid(u_out_valid), .out_ready(out_ready), .out_sum(u_out_sum));

    addertree_pipe_param #(.NUM_IN(25), .IN_W(8), .REG_EVERY(3)) sw25 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(r25), .in_data(sw_data),
        .in_acc(sw_ctl), .in_first(sw_ctl), .in_last(sw_ctl),
        .out_valid(v25), .out_ready(sw_ready), .out_sum(s25));

    addertree_pipe_param #(.NUM_IN(3), .IN_W(8), .REG_EVERY(1)) sw3 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(r3), .in_data(sw_data[23:0]),
        .in_acc(sw_ctl), .in_first(sw_ctl), .in_last(sw_ctl),
        .out_valid(v3), .out_ready(sw_ready), .out_sum(s3));

    addertree_pipe_param #(.NUM_IN(4), .IN_W(8), .REG_EVERY(1)) sw4 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(r4), .in_data(sw_data[31:0]),
        .in_acc(sw_ctl), .in_first(sw_ctl), .in_last(sw_ctl),
        .out_valid(v4), .out_ready(sw_ready), .out_sum(s4));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [N*IW-1:0] pk(input int base, input int step);
        logic [N*IW-1:0] d;
        for (int k = 0; k < N; k++) d[k*IW +: IW] = IW'(base + k * step);
        return d;
    endfunction

    function automatic logic [N*IW-1:0] p0(input int v);
        logic [N*IW-1:0] d;
        d = '0;
        d[IW-1:0] = IW'(v);
        return d;
    endfunction

    // Model: results are fixed at accept time in accept order (signed and unsigned views).
    typedef struct packed { logic [OW-1:0] s; logic [OW-1:0] u; } exp_t;
    exp_t          q[$];
    exp_t          e;
    logic [OW-1:0] macc_s = '0, macc_u = '0, bs, bu, prev_s, prev_u;
    longint        vs, vu;
    bit            prev_stall = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            macc_s     = '0;
            macc_u     = '0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            check("u_ctrl_match", {u_in_ready, u_out_valid}, {in_ready, out_valid});
            if (prev_stall)
                check("hold_while_stalled", {out_valid, out_sum, u_out_sum}, {1'b1, prev_s, prev_u});
            if (out_valid && out_ready) begin
                n_out++;
                check("output_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("out_sum", out_sum, e.s);
                    check("u_out_sum", u_out_sum, e.u);
                end
            end
            if (in_valid && in_ready) begin
                vs = 0;
                vu = 0;
                for (int k = 0; k < N; k++) begin
                    vs += longint'($signed(in_data[k*IW +: IW]));
                    vu += longint'(in_data[k*IW +: IW]);
                end
                bs = vs[OW-1:0];
                bu = vu[OW-1:0];
                if (!in_acc) q.push_back('{bs, bu});
                else begin
                    bs = bs + (in_first ? '0 : macc_s);
                    bu = bu + (in_first ? '0 : macc_u);
                    if (in_last) begin
                        q.push_back('{bs, bu});
                        macc_s = '0;
                        macc_u = '0;
                    end else begin
                        macc_s = bs;
                        macc_u = bu;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = out_sum;
            prev_u     = u_out_sum;
        end
    end

    task automatic send(input logic [N*IW-1:0] d, input logic a, input logic f, input logic l);
        int g;
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_acc   = a;
        in_first = f;
        in_last  = l;
        g  = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!ok && g < 200);
        check("send_accept", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [OW-1:0] s, output logic [OW-1:0] us);
        int g;
        bit got;
        g   = 0;
        got = 1'b0;
        s   = '0;
        us  = '0;
        while (!got && g < 60) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got = 1'b1;
                s   = out_sum;
                us  = u_out_sum;
            end
            g++;
        end
        check("wait_out", got, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [OW-1:0] rs, ru, r6 [3];
    int            lat, n0, l25, l3, l4;
    longint        e25, e3, e4;
    logic [20:0]   g25;
    logic [17:0]   g3, g4;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_state", {out_valid, out_sum, in_ready, u_out_valid, u_out_sum},
              {1'b0, {OW{1'b0}}, 1'b1, 1'b0, {OW{1'b0}}});

        // 1: pass-through, latency and literal sums
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = pk(1, 1); in_acc = 1'b0; in_first = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 10);
        check("t1_latency", lat, 3);
        check("t1_sum_1to9", out_sum, 45);
        @(posedge clk); #1;
        send(pk(-1, 0), 1'b0, 1'b0, 1'b0);
        wait_out(rs, ru);
        check("t1_all_neg1", rs, 28'hFFFFFF7);
        check("t1_all_ffff_u", ru, 589815);

        // 2: 4-beat accumulate frame
        n0 = n_out;
        for (int i = 0; i < 4; i++) send(pk(2, 0), 1'b1, i == 0, i == 3);
        wait_out(rs, ru);
        check("t2_frame_sum", rs, 72);
        repeat (5) @(posedge clk); #1;
        check("t2_single_output", n_out - n0, 1);

        // pass beat inside open frame; frame without first after a completed one
        fork
            begin
                send(p0(10), 1'b1, 1'b1, 1'b0);
                send(p0(7),  1'b0, 1'b0, 1'b0);
                send(p0(20), 1'b1, 1'b0, 1'b1);
                send(p0(4),  1'b1, 1'b0, 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) wait_out(r6[i], ru);
            end
        join
        check("t6_interleave_pass", r6[0], 7);
        check("t6_frame_sum", r6[1], 30);
        check("t6_restart_from_zero", r6[2], 4);

        // 3: back-pressure, out_ready toggles every 2 cycles
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) send(pk(i * 3 + 1, i - 4), 1'b0, 1'b0, 1'b0);
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk); #1;
                    out_ready = ((c / 2) % 2) != 0;
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("t3_result_count", n_out - n0, 10);

        // 4: 2^ACC_EXT+1 beats of 0xFFFF
        for (int i = 0; i < 257; i++) send(pk(-1, 0), 1'b1, i == 0, i == 256);
        wait_out(rs, ru);
        check("t4_unsigned_frame", ru, 151582455);
        check("t4_signed_frame", rs, 268433143);

        // random mix with random back-pressure
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send({$urandom, $urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            end
            begin
                for (int c = 0; c < 70; c++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;

        // 5: reset mid-frame
        for (int i = 0; i < 3; i++) send(pk(1, 0), 1'b1, i == 0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_idle_after_reset", {out_valid, in_ready}, 2'b01);
        n0 = n_out;
        @(posedge clk); #1;
        send(p0(5), 1'b1, 1'b1, 1'b1);
        wait_out(rs, ru);
        check("t5_fresh_frame", rs, 5);
        repeat (5) @(posedge clk); #1;
        check("t5_no_stale", n_out - n0, 1);

        // 6: parameter sweep, single beats, latency and sum
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            for (int b = 0; b < 25; b++) sw_data[b*8 +: 8] = (t == 0) ? 8'(b + 1) : 8'($urandom);
            e25 = 0; e3 = 0; e4 = 0;
            for (int b = 0; b < 25; b++) begin
                e25 += longint'($signed(sw_data[b*8 +: 8]));
                if (b < 3) e3 += longint'($signed(sw_data[b*8 +: 8]));
                if (b < 4) e4 += longint'($signed(sw_data[b*8 +: 8]));
            end
            if (t == 0) check("sw_model_pin", {e25[15:0], e3[15:0], e4[15:0]}, {16'd325, 16'd6, 16'd10});
            sw_valid = 1'b1;
            @(negedge clk);
            check("sw_in_ready", {r25, r3, r4}, 3'b111);
            @(posedge clk); #1;
            sw_valid = 1'b0;
            l25 = 0; l3 = 0; l4 = 0; g25 = '0; g3 = '0; g4 = '0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (v25 && l25 == 0) begin l25 = c; g25 = s25; end
                if (v3 && l3 == 0) begin l3 = c; g3 = s3; end
                if (v4 && l4 == 0) begin l4 = c; g4 = s4; end
            end
            check("sw25_latency", l25, 4);
            check("sw3_latency", l3, 2);
            check("sw4_latency", l4, 3);
            check("sw25_sum", g25, e25[20:0]);
            check("sw3_sum", g3, e3[17:0]);
            check("sw4_sum", g4, e4[17:0]);
        end

        check("model_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
